nn_and_trainer: RTL and testbench
=================================

// Module: nn_and_trainer
// PURPOSE
// Training engine for the 2-input single-neuron gate classifiers (AND/OR/NAND/NOR...). It runs the
// backward/learning direction of the forward inference path: it sweeps the 4-row truth table, computes
// the neuron output, and applies the perceptron update rule to w0/w1/bias until an error-free epoch
// or an epoch limit. Trained weights feed the inference neuron's w0, w1 and bias inputs.
// PARAMETERS
// MAX_EPOCHS  64  epoch limit before abort without convergence (1..255)
// PORTS
// clk         in   1   clock, all logic on rising edge
// rst_n       in   1   synchronous active-low reset
// start       in   1   1-cycle request; accepted only in IDLE
// truth       in   4   target table; truth[i] = target for sample i; sampled at start
// w0_init     in   16  signed initial w0; sampled at start
// w1_init     in   16  signed initial w1; sampled at start
// bias_init   in   16  signed initial bias; sampled at start
// lr          in   8   unsigned learning rate (integer step); sampled at start
// w0          out  16  signed current/trained weight for x0
// w1          out  16  signed current/trained weight for x1
// bias        out  16  signed current/trained bias
// busy        out  1   high while training
// done        out  1   1-cycle pulse when training ends
// converged   out  1   1 = last epoch error-free; valid from done until next accepted start
// epoch_cnt   out  8   epochs completed in current/last run
// BEHAVIOUR
// - Reset (rst_n=0 at edge): state IDLE; all outputs 0 next cycle; applies mid-run too (run aborted, no done).
// - Sample order i=0..3: x1=i[0], x0=i[1]. AND = truth 4'b1000, OR = 4'b1110, XOR = 4'b0110.
// - States: IDLE -> EVAL -> UPDATE -> (EVAL | DONE) -> IDLE.
// - IDLE: start=1 latches truth/lr/inits, loads w0/w1/bias from inits, epoch_cnt=0, converged=0,
//   sample=0, epoch error flag=0; next state EVAL. busy=1 from the cycle after start through last UPDATE.
// - start while busy or in DONE: ignored, no effect.
// - EVAL (1 cycle): net = x0*w0 + x1*w1 + bias in 18-bit signed (no overflow); y = (net > 0) ? 1 : 0
//   (strict; net=0 gives 0). err = truth[i] - y in {-1,0,+1}, registered.
// - UPDATE (1 cycle): if err!=0: w0 += err*lr*x0, w1 += err*lr*x1, bias += err*lr, set epoch error flag.
//   Each sum saturates to [-32768, 32767] (never wraps). err=0: weights unchanged.
// - After UPDATE of sample 3: epoch_cnt += 1. If flag=0 -> DONE with converged=1; else if
//   epoch_cnt == MAX_EPOCHS -> DONE with converged=0; else clear flag, sample=0, EVAL.
// - Epoch = 8 cycles; busy high exactly 8*E cycles for E epochs; done pulses the cycle after busy falls.
// - DONE (1 cycle): done=1, busy=0; next IDLE. w0/w1/bias/epoch_cnt/converged hold until next start.
// - w0/w1/bias are live during training (change after each UPDATE with err!=0).
// - lr=0: no weight changes; converges only if inits already classify all rows correctly.
// TESTING
// 1 AND: truth=1000, inits 0/0/0, lr=1 -> converged=1, epoch_cnt=6, w0=2 w1=1 bias=-2, busy 48 cycles.
// 2 XOR: truth=0110, inits 0, lr=1 -> converged=0, epoch_cnt=64, busy 512 cycles, done 1 pulse.
// 3 Saturation: truth=0010, w0_init=0 w1_init=32767 bias_init=-32768 lr=1 -> after sample 1
//   UPDATE, w1=32767 (no wrap), bias=-32767.
// 4 Pre-trained: truth=1000, w0=2 w1=1 bias=-2, lr=5 -> epoch_cnt=1, converged=1, weights unchanged.
// 5 Reset mid-run: assert rst_n=0 during epoch 3 of test 1 -> all outputs 0 next cycle, no done;
//   a later start reruns test 1 with identical results.
// 6 start held high whole run plus extra start pulses while busy -> single run; results as test 1.

Source files
------------

// File: rtl/nn_and_trainer.sv
// Perceptron training engine for a 2-input threshold neuron: sweeps the 4-row truth table,
// applies the saturating perceptron update and stops on an error-free epoch or the epoch limit.
module nn_and_trainer #(
   parameter int MAX_EPOCHS = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [3:0]  truth,
   input  logic [15:0] w0_init,
   input  logic [15:0] w1_init,
   input  logic [15:0] bias_init,
   input  logic [7:0]  lr,
   output logic [15:0] w0,
   output logic [15:0] w1,
   output logic [15:0] bias,
   output logic        busy,
   output logic        done,
   output logic        converged,
   output logic [7:0]  epoch_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         truth_q, truth_d;
   logic [7:0]         lr_q, lr_d;
   logic signed [15:0] w0_q, w0_d;
   logic signed [15:0] w1_q, w1_d;
   logic signed [15:0] bias_q, bias_d;
   logic [7:0]         epoch_cnt_q, epoch_cnt_d;
   logic               converged_q, converged_d;
   logic [1:0]         sample_q, sample_d;
   logic               flag_q, flag_d;
   logic signed [1:0]  err_q, err_d;

   logic               x0, x1, y, flag_now;
   logic signed [17:0] net, step;
   logic [7:0]         epoch_nxt;

   function automatic logic signed [17:0] sext16(input logic signed [15:0] v);
      return {{2{v[15]}}, v};
   endfunction

   // Clamp an 18-bit sum back into the 16-bit signed weight range.
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767)
         return 16'sh7fff;
      else if (v < -18'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      truth_d     = truth_q;
      lr_d        = lr_q;
      w0_d        = w0_q;
      w1_d        = w1_q;
      bias_d      = bias_q;
      epoch_cnt_d = epoch_cnt_q;
      converged_d = converged_q;
      sample_d    = sample_q;
      flag_d      = flag_q;
      err_d       = err_q;

      // Row index i maps to inputs as x0 = i[1], x1 = i[0].
      x0 = sample_q[1];
      x1 = sample_q[0];

      net = sext16(bias_q);
      if (x0) net = net + sext16(w0_q);
      if (x1) net = net + sext16(w1_q);
      y = (net > 18'sd0);

      step = $signed({10'd0, lr_q});
      if (err_q[1]) step = -step;

      flag_now  = flag_q | (err_q != 2'sd0);
      epoch_nxt = epoch_cnt_q + 8'd1;

      case (state_q)
         IDLE: begin
            if (start) begin
               truth_d     = truth;
               lr_d        = lr;
               w0_d        = w0_init;
               w1_d        = w1_init;
               bias_d      = bias_init;
               epoch_cnt_d = 8'd0;
               converged_d = 1'b0;
               sample_d    = 2'd0;
               flag_d      = 1'b0;
               err_d       = 2'sd0;
               state_d     = EVAL;
            end
         end
         EVAL: begin
            err_d   = $signed({1'b0, truth_q[sample_q]}) - $signed({1'b0, y});
            state_d = UPDATE;
         end
         UPDATE: begin
            if (err_q != 2'sd0) begin
               if (x0) w0_d = sat16(sext16(w0_q) + step);
               if (x1) w1_d = sat16(sext16(w1_q) + step);
               bias_d = sat16(sext16(bias_q) + step);
            end
            sample_d = sample_q + 2'd1;
            flag_d   = flag_now;
            state_d  = EVAL;
            if (sample_q == 2'd3) begin
               epoch_cnt_d = epoch_nxt;
               if (!flag_now) begin
                  converged_d = 1'b1;
                  state_d     = DONE;
               end else if (epoch_nxt == 8'(MAX_EPOCHS)) begin
                  state_d = DONE;
               end else begin
                  flag_d = 1'b0;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         truth_q     <= 4'd0;
         lr_q        <= 8'd0;
         w0_q        <= 16'sd0;
         w1_q        <= 16'sd0;
         bias_q      <= 16'sd0;
         epoch_cnt_q <= 8'd0;
         converged_q <= 1'b0;
         sample_q    <= 2'd0;
         flag_q      <= 1'b0;
         err_q       <= 2'sd0;
      end else begin
         state_q     <= state_d;
         truth_q     <= truth_d;
         lr_q        <= lr_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         bias_q      <= bias_d;
         epoch_cnt_q <= epoch_cnt_d;
         converged_q <= converged_d;
         sample_q    <= sample_d;
         flag_q      <= flag_d;
         err_q       <= err_d;
      end
   end

   assign w0        = w0_q;
   assign w1        = w1_q;
   assign bias      = bias_q;
   assign busy      = (state_q == EVAL) || (state_q == UPDATE);
   assign done      = (state_q == DONE);
   assign converged = converged_q;
   assign epoch_cnt = epoch_cnt_q;

endmodule

// File: tb/tb_nn_and_trainer.sv
// Randomized bench for nn_and_trainer against an epoch-level perceptron model.
module tb_nn_and_trainer;

   localparam int MAXE = 64;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  truth;
   logic [15:0] w0_init, w1_init, bias_init;
   logic [7:0]  lr;
   logic [15:0] w0, w1, bias;
   logic        busy, done, converged;
   logic [7:0]  epoch_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   nn_and_trainer #(.MAX_EPOCHS(MAXE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .truth(truth),
      .w0_init(w0_init), .w1_init(w1_init), .bias_init(bias_init), .lr(lr),
      .w0(w0), .w1(w1), .bias(bias), .busy(busy), .done(done),
      .converged(converged), .epoch_cnt(epoch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   function automatic int sat(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Epoch-level perceptron reference.
   task automatic model(input logic [3:0] t, input int a, input int b, input int c, input int l,
                        output int ep, output int cv, output int fw0, output int fw1, output int fb);
      int w0m, w1m, bm, net, y, e, bad;
      w0m = a; w1m = b; bm = c; ep = 0; cv = 0;
      for (int k = 1; k <= MAXE; k++) begin
         bad = 0;
         for (int i = 0; i < 4; i++) begin
            int xa, xb;
            xb = i % 2;
            xa = i / 2;
            net = xa * w0m + xb * w1m + bm;
            y = (net > 0) ? 1 : 0;
            e = int'(t[i]) - y;
            if (e != 0) begin
               bad = 1;
               w0m = sat(w0m + e * l * xa);
               w1m = sat(w1m + e * l * xb);
               bm  = sat(bm + e * l);
            end
         end
         ep = k;
         if (bad == 0) begin
            cv = 1;
            break;
         end
      end
      fw0 = w0m; fw1 = w1m; fb = bm;
   endtask

   task automatic do_run(input string tag, input logic [3:0] t, input int a, input int b,
                         input int c, input int l, input bit hold,
                         input int probe_at, input int pw1, input int pb);
      int ep, cv, fw0, fw1, fb, busy_n, done_n, cyc;
      bit seen;
      model(t, a, b, c, l, ep, cv, fw0, fw1, fb);
      @(negedge clk);
      truth = t; w0_init = 16'(a); w1_init = 16'(b); bias_init = 16'(c); lr = 8'(l);
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      busy_n = 0; done_n = 0; cyc = 0; seen = 0;
      while (!seen && cyc < 3000) begin
         if (cyc == probe_at) begin
            chk({tag, "_probe_w1"}, int'($signed(w1)), pw1);
            chk({tag, "_probe_bias"}, int'($signed(bias)), pb);
         end
         if (hold && (cyc % 7 == 3)) start = ~start;
         if (busy) busy_n++;
         if (done) begin
            seen = 1;
            start = 1'b0;
         end else begin
            @(negedge clk);
         end
         cyc++;
      end
      chk({tag, "_done_seen"}, int'(seen), 1);
      chk({tag, "_busy_cycles"}, busy_n, 8 * ep);
      chk({tag, "_conv"}, int'(converged), cv);
      chk({tag, "_epochs"}, int'(epoch_cnt), ep);
      chk({tag, "_w0"}, int'($signed(w0)), fw0);
      chk({tag, "_w1"}, int'($signed(w1)), fw1);
      chk({tag, "_bias"}, int'($signed(bias)), fb);
      @(negedge clk);
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_busy_after"}, int'(busy), 0);
      chk({tag, "_hold_w0"}, int'($signed(w0)), fw0);
      chk({tag, "_hold_conv"}, int'(converged), cv);
   endtask

   function automatic int rnd_w();
      case ($urandom_range(0, 5))
         0: return 32767 - int'($urandom_range(0, 2));
         1: return -32768 + int'($urandom_range(0, 2));
         default: return int'($urandom_range(0, 8)) - 4;
      endcase
   endfunction

   initial begin
      int seen_done;
      rst_n = 1'b0; start = 1'b0; truth = 4'd0;
      w0_init = 16'd0; w1_init = 16'd0; bias_init = 16'd0; lr = 8'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_w0", int'(w0), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_epoch", int'(epoch_cnt), 0);
      rst_n = 1'b1;

      do_run("and", 4'b1000, 0, 0, 0, 1, 0, -1, 0, 0);
      chk("and_w0_abs", int'($signed(w0)), 2);
      chk("and_w1_abs", int'($signed(w1)), 1);
      chk("and_bias_abs", int'($signed(bias)), -2);
      chk("and_epoch_abs", int'(epoch_cnt), 6);
      do_run("xor", 4'b0110, 0, 0, 0, 1, 0, -1, 0, 0);
      chk("xor_epoch_abs", int'(epoch_cnt), 64);
      chk("xor_conv_abs", int'(converged), 0);
      do_run("sat", 4'b0010, 0, 32767, -32768, 1, 0, 4, 32767, -32767);
      do_run("pre", 4'b1000, 2, 1, -2, 5, 0, -1, 0, 0);
      chk("pre_epoch_abs", int'(epoch_cnt), 1);
      chk("pre_w0_abs", int'($signed(w0)), 2);

      // Reset during epoch 3 of the AND run.
      @(negedge clk);
      truth = 4'b1000; w0_init = 16'd0; w1_init = 16'd0; bias_init = 16'd0; lr = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (19) @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      rst_n = 1'b0;
      seen_done = 0;
      @(negedge clk);
      chk("mrst_w0", int'(w0), 0);
      chk("mrst_w1", int'(w1), 0);
      chk("mrst_bias", int'(bias), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_conv", int'(converged), 0);
      chk("mrst_epoch", int'(epoch_cnt), 0);
      repeat (2) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      chk("mrst_no_done", seen_done, 0);
      do_run("rerun", 4'b1000, 0, 0, 0, 1, 0, -1, 0, 0);
      do_run("hold", 4'b1000, 0, 0, 0, 1, 1, -1, 0, 0);
      chk("hold_epoch_abs", int'(epoch_cnt), 6);

      for (int n = 0; n < 12; n++) begin
         do_run($sformatf("rnd%0d", n), 4'($urandom_range(0, 15)), rnd_w(), rnd_w(), rnd_w(),
                (n % 4 == 0) ? 200 + int'($urandom_range(0, 55)) : int'($urandom_range(0, 3)),
                0, -1, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
